// File: rtl/disp_src_sel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | disp_sel_pkg : shared types, width helper and constants              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package disp_sel_pkg;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    LOCKED = 2'd1,
    SETTLE = 2'd2
  } sel_state_t;

  // Never returns zero so that single-value counters still get a real bit.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam logic [63:0] c_data_zero = '0;

endpackage
`default_nettype wire

// File: rtl/disp_src_sel_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | disp_src_sel_if : select/data/result bundle; scan_en with AUTO_SCAN_EN |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface disp_src_sel_if
  import disp_sel_pkg::*;
#(
  parameter int NCH = 3,
  parameter int W   = 4
);
  localparam int CW = clog2w(NCH);

  logic [NCH-1:0]   sel;
  logic [NCH*W-1:0] data;
  logic [W-1:0]     out;
  logic             ch_valid;
  logic [CW-1:0]    ch_idx;
  logic             changed;

`ifdef AUTO_SCAN_EN
  logic             scan_en;

  modport master (output sel, data, scan_en, input out, ch_valid, ch_idx, changed);
  modport slave  (input sel, data, scan_en, output out, ch_valid, ch_idx, changed);
`else
  modport master (output sel, data, input out, ch_valid, ch_idx, changed);
  modport slave  (input sel, data, output out, ch_valid, ch_idx, changed);
`endif

endinterface
`default_nettype wire

// File: rtl/disp_src_sel_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sel_sync : parametrised-width two-flop synchroniser, async reset     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sel_sync #(
  parameter int WIDTH = 1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [WIDTH-1:0] i_d,
  output logic      [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/disp_src_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | disp_src_sel : debounced priority selector of display sources.       |
// | Optional AUTO_SCAN_EN adds scan_en round-robin cycling. Rev 1.0      |
// +----------------------------------------------------------------------+
module disp_src_sel
  import disp_sel_pkg::*;
#(
  parameter int NCH  = 3,
  parameter int W    = 4,
  parameter int HOLD = 4
`ifdef AUTO_SCAN_EN
  ,
  parameter int SCAN_DIV = 50000000
`endif
) (
  input wire logic        clk,
  input wire logic        rst_n,
  disp_src_sel_if.slave   bus
);

  localparam int CW   = clog2w(NCH);
  localparam int CNTW = clog2w(HOLD + 1);
  localparam logic [CNTW-1:0] c_cnt_last = CNTW'(HOLD - 1);

  sel_state_t    r_state, w_nxt_state;
  logic [CW:0]   r_pend,  w_nxt_pend;      // {valid, idx}
  logic [CW:0]   r_com,   w_nxt_com;
  logic [CNTW-1:0] r_cnt, w_nxt_cnt;
  logic          r_changed, w_nxt_changed;
  logic [W-1:0]  r_out, w_out_nxt;
  logic [NCH-1:0] w_sel_s;
  logic [CW:0]   w_cand;

  sel_sync #(.WIDTH(NCH)) u_sel_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.sel),
    .o_q   (w_sel_s)
  );

`ifdef AUTO_SCAN_EN
  localparam int DIVW = clog2w(SCAN_DIV);
  localparam logic [DIVW-1:0] c_div_last = DIVW'(SCAN_DIV - 1);

  logic            w_scan_s;
  logic            r_scan_act;
  logic [DIVW-1:0] r_div;
  logic [CW-1:0]   w_scan_idx;

  sel_sync #(.WIDTH(1)) u_scan_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.scan_en),
    .o_q   (w_scan_s)
  );

  // The first synced-high cycle only restarts the divider, giving a full period on idx 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_act <= 1'b0;
      r_div      <= '0;
    end else begin
      r_scan_act <= w_scan_s;
      if (!w_scan_s || !r_scan_act || r_div == c_div_last)
        r_div <= '0;
      else
        r_div <= r_div + DIVW'(1);
    end
  end
`endif

  // Highest asserted bit wins; loop order makes later indices override.
  always_comb begin
    w_cand = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_sel_s[i])
        w_cand = {1'b1, CW'(i)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= NONE;
      r_pend    <= '0;
      r_com     <= '0;
      r_cnt     <= '0;
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_pend    <= w_nxt_pend;
      r_com     <= w_nxt_com;
      r_cnt     <= w_nxt_cnt;
      r_changed <= w_nxt_changed;
    end
  end

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_pend    = r_pend;
    w_nxt_com     = r_com;
    w_nxt_cnt     = r_cnt;
    w_nxt_changed = 1'b0;
    case (r_state)
      NONE, LOCKED: begin
        if (w_cand != r_com) begin
          w_nxt_pend  = w_cand;
          w_nxt_cnt   = '0;
          w_nxt_state = SETTLE;
        end
      end
      SETTLE: begin
        if (w_cand != r_pend) begin
          w_nxt_pend = w_cand;
          w_nxt_cnt  = '0;
          if (w_cand == r_com)
            w_nxt_state = r_com[CW] ? LOCKED : NONE;
        end else if (r_cnt == c_cnt_last) begin
          w_nxt_com     = r_pend;
          w_nxt_changed = 1'b1;
          w_nxt_state   = r_pend[CW] ? LOCKED : NONE;
        end else begin
          w_nxt_cnt = r_cnt + CNTW'(1);
        end
      end
      default: begin
        w_nxt_state = NONE;
      end
    endcase
`ifdef AUTO_SCAN_EN
    w_scan_idx = (r_com[CW-1:0] == CW'(NCH - 1)) ? '0 : r_com[CW-1:0] + CW'(1);
    // Scan overrides the switches; on exit the LOCKED rule re-evaluates cand.
    if (w_scan_s) begin
      if (!r_scan_act)
        w_nxt_com = {1'b1, CW'(0)};
      else if (r_div == c_div_last)
        w_nxt_com = {1'b1, w_scan_idx};
      else
        w_nxt_com = r_com;
      w_nxt_pend    = w_nxt_com;
      w_nxt_cnt     = '0;
      w_nxt_state   = LOCKED;
      w_nxt_changed = (w_nxt_com != r_com);
    end
`endif
  end

  always_comb begin
    w_out_nxt    = r_com[CW] ? bus.data[r_com[CW-1:0]*W +: W] : c_data_zero[W-1:0];
    bus.out      = r_out;
    bus.ch_valid = r_com[CW];
    bus.ch_idx   = r_com[CW-1:0];
    bus.changed  = r_changed;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_out <= c_data_zero[W-1:0];
    else
      r_out <= w_out_nxt;
  end

endmodule
`default_nettype wire

// File: doc/disp_src_sel.md
Name: disp_src_sel

Overview:
- Parametrised, registered successor to the display-source selector.
- Chooses one of NCH W-bit display sources (e.g. hex, binary, base-ten) from a vector of raw select switches. The highest-index asserted switch wins.
- Synchronises and debounces the select vector, so the 7-segment path never sees glitches while switches move.
- Sits between the number-format converters and the segment decoder.

Parameters:
- NCH, 3, number of source channels (>=2)
- W, 4, data width per channel
- HOLD, 4, consecutive stable cycles required before a new selection commits (>=1)
- SCAN_DIV, 50000000, clock cycles per channel in auto-scan (used only with AUTO_SCAN_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- sel  in  NCH  raw select switches; bit i requests channel i
- data  in  NCH*W  channel i occupies data[i*W +: W]
- out  out  W  registered selected data
- ch_valid  out  1  a channel is committed (sel was non-zero)
- ch_idx  out  CW  committed channel index, CW = max(1, clog2(NCH))
- changed  out  1  one-cycle pulse when the committed selection changes

Behaviour:
- Reset: clock and reset as stated above. While rst_n=0, all of the following are 0 immediately: out, ch_valid, ch_idx, changed, sync flops, pending, counter. The FSM goes to NONE. Reset during SETTLE discards the pending selection.
- Sync: sel passes through 2 flops, giving sel_s.
- Priority encode sel_s: the highest set bit i gives cand = {1, i}; all-zero gives cand = {0, 0}.
- FSM states:
  - NONE: committed invalid.
  - LOCKED: committed valid.
  - SETTLE: pending differs from committed.
- FSM transitions:
  - From NONE or LOCKED: if cand != committed, then pending <= cand, cnt <= 0, go to SETTLE.
  - In SETTLE, if cand != pending: pending <= cand, cnt <= 0. This restarts the count, including on a return to the committed value, which goes back to NONE or LOCKED with no commit.
  - In SETTLE, if cand == pending and cnt == HOLD-1: commit pending, assert changed next cycle, go to LOCKED (valid) or NONE (invalid).
  - Otherwise in SETTLE: cnt++.
- Latency: with sel stable from edge k, committed and ch_idx/ch_valid update at edge k+2+HOLD, changed is high for the cycle following that edge, and out shows new-channel data from edge k+3+HOLD.
- Data path: out <= ch_valid ? data[ch_idx] : 0, every cycle. Live data changes appear with 1-cycle latency; data is never held.
- cnt width: clog2(HOLD+1); it never exceeds HOLD-1.
- changed is never asserted for a selection equal to the current commit.

Optional Feature:
- Macro: AUTO_SCAN_EN.
- Defined:
  - Adds input scan_en (1 bit), which passes through the same 2-flop sync.
  - While synced scan_en=1: sel is ignored. Committed advances 0,1,...,NCH-1,0 every SCAN_DIV cycles, starting at idx 0 with ch_valid=1 on the first synced-high cycle. changed pulses on each advance.
  - On scan_en falling: the FSM re-enters SETTLE with the current cand, and the normal HOLD rule applies.
  - Divider counter: clog2(SCAN_DIV) bits, cleared by reset and whenever scan_en=0.
- Undefined: no scan_en port, no divider, no scan logic.

Decomposition:
- Package disp_sel_pkg:
  - FSM state enum (NONE, LOCKED, SETTLE)
  - clog2-based width function for CW and the cnt width
  - reset/default data constant (all zeros)
- One sub-module: sel_sync, a parametrised-width 2-flop synchroniser with async active-low reset. It is instantiated for sel, and for scan_en when enabled.

Test Plan (NCH=3, W=4, HOLD=4):
- Reset, sel=3'b001, data={4'h3,4'h5,4'hA} -> out=4'hA, ch_idx=0, ch_valid=1 at edge 7. changed is high for exactly 1 cycle after edge 6.
- sel=3'b011, then 3'b111 (each held 10 cycles) -> ch_idx goes 1 (out=4'h5), then 2 (out=4'h3). Priority holds, and there is one changed pulse per transition.
- Glitch: locked on idx0, sel=3'b010 for 3 cycles then back to 3'b001 -> ch_idx stays 0, changed never asserts.
- sel=3'b000 held -> out=0, ch_valid=0, ch_idx=0, one changed pulse.
- Locked on idx2, data[11:8] changes 4'h3->4'h9 -> out=4'h9 one edge later, no changed pulse.
- rst_n pulsed low for 1 cycle mid-SETTLE (cnt=2) -> all outputs 0 asynchronously. After release, the full 2+HOLD commit latency applies again.
- AUTO_SCAN_EN build, SCAN_DIV=5, scan_en=1 -> ch_idx sequence 0,1,2,0 at 5-cycle spacing.
